// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: ramps PWM duty toward a target in fixed steps at a programmable tick rate.
// Define PWM_RAMP_SOFTSTOP_EN to make stop ramp the duty down to 0 instead of cutting it at once.
module pwm_ramp_controller #(
   parameter int WORD_LENGTH = 8,
   parameter int TICK_BITS   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [WORD_LENGTH-1:0] target_duty,
   input  logic [WORD_LENGTH-1:0] step,
   input  logic [TICK_BITS-1:0]   tick_period,
   input  logic [1:0]             freq_sel,
   output logic [WORD_LENGTH-1:0] duty_out,
   output logic [1:0]             freq_out,
   output logic                   pwm_enable,
   output logic                   busy,
   output logic                   at_target,
   output logic                   done
);
`ifdef PWM_RAMP_SOFTSTOP_EN
   typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOPPING} state_t;
   localparam state_t STOP_DEST = STOPPING;
`else
   typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;
   localparam state_t STOP_DEST = IDLE;
`endif
   localparam logic [WORD_LENGTH-1:0] MAX_DUTY = WORD_LENGTH'(100);
   state_t state, state_nx;
   logic [WORD_LENGTH-1:0] duty, tgt, stp, duty_nx;
   logic [TICK_BITS-1:0] per, cnt;
   logic [WORD_LENGTH:0] up_sum, dn_gap;
   logic tick, arrive, cap, halt, done_nx;
   // one extra bit on the sums keeps the step arithmetic from wrapping
   always_comb begin
      up_sum  = {1'b0, duty} + {1'b0, stp};
      dn_gap  = {1'b0, duty} - {1'b0, tgt};
      duty_nx = duty < tgt ? (up_sum >= {1'b0, tgt} ? tgt : up_sum[WORD_LENGTH-1:0])
                           : (dn_gap <= {1'b0, stp} ? tgt : duty - stp);
   end
   assign tick   = cnt == per;
   assign arrive = tick && duty_nx == tgt;
   always_ff @(posedge clk or posedge reset)
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   always_comb begin
      state_nx = state;
      cap      = 1'b0;
      halt     = 1'b0;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            cap      = start;
            state_nx = start ? RAMP : IDLE;
         end
         RAMP: begin
            halt     = stop;
            done_nx  = !stop && arrive;
            state_nx = stop ? STOP_DEST : arrive ? HOLD : RAMP;
         end
         HOLD: begin
            halt     = stop;
            cap      = !stop && start;
            state_nx = stop ? STOP_DEST : start ? RAMP : HOLD;
         end
`ifdef PWM_RAMP_SOFTSTOP_EN
         STOPPING: begin
            done_nx  = arrive;
            state_nx = arrive ? IDLE : STOPPING;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         duty     <= '0;
         tgt      <= '0;
         stp      <= WORD_LENGTH'(1);
         per      <= '0;
         cnt      <= '0;
         freq_out <= '0;
         done     <= 1'b0;
      end else begin
         done <= done_nx;
         if (cap) begin
            tgt      <= target_duty > MAX_DUTY ? MAX_DUTY : target_duty;
            stp      <= step == '0 ? WORD_LENGTH'(1) : step;
            per      <= tick_period;
            freq_out <= freq_sel;
            cnt      <= '0;
         end else if (halt) begin
            tgt <= '0;
            cnt <= '0;
            if (STOP_DEST == IDLE)
               duty <= '0;
         end else if (state != IDLE && state != HOLD) begin
            cnt <= tick ? '0 : cnt + TICK_BITS'(1);
            if (tick)
               duty <= duty_nx;
         end
      end
   always_comb begin
      duty_out   = duty;
      busy       = state != IDLE;
      pwm_enable = state != IDLE;
      at_target  = state == HOLD;
   end
endmodule

// File: doc/pwm_ramp_controller.md
# pwm_ramp_controller

Sequencer that drives the duty-cycle and frequency-select inputs of the PWM generator. On command it ramps the duty cycle (0–100 %) from its present value toward a target in fixed steps at a programmable tick rate, holds it, and shuts the PWM down on stop. It sits between register/control logic and the PWM instance, replacing direct static wiring of duty and frequency.

## Interface
- WORD_LENGTH, 8: width of duty values (percent, 0–100).
- TICK_BITS, 16: width of the ramp tick period.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command: capture the config inputs and ramp to target_duty.
- stop  input  1  one-cycle command: shut down the PWM.
- target_duty  input  WORD_LENGTH  target duty in percent; values >100 are clamped to 100 at capture.
- step  input  WORD_LENGTH  duty increment per tick; 0 is treated as 1.
- tick_period  input  TICK_BITS  one duty update every tick_period+1 cycles.
- freq_sel  input  2  frequency select passed to the PWM.
- duty_out  output  WORD_LENGTH  duty to the PWM dutyCycle input.
- freq_out  output  2  to the PWM frequency input.
- pwm_enable  output  1  high when the PWM output is allowed (gate/enable).
- busy  output  1  high in any state except IDLE.
- at_target  output  1  high in HOLD.
- done  output  1  one-cycle pulse on reaching the target, or on completing a soft stop.

## Operation
- States: IDLE, RAMP, HOLD, STOPPING (STOPPING exists only with the macro).
- Capture (on an accepted start): tgt = min(target_duty, 100); stp = max(step, 1); per = tick_period; freq_out = freq_sel; tick counter cleared.
- IDLE: duty_out = 0, pwm_enable = 0. start → capture → RAMP. stop is ignored.
- RAMP: the tick counter increments each cycle. When it equals per, it clears and duty updates:
  - if duty < tgt: duty = min(duty+stp, tgt).
  - if duty > tgt: duty = max(duty−stp, tgt).
  - Arithmetic is done in WORD_LENGTH+1 bits, so there is no wrap.
  - When the updated duty equals tgt, go to HOLD and assert done.
  - start during RAMP is ignored.
- HOLD: duty is constant. start → capture → RAMP (retarget up or down from the current duty). If the new tgt equals the current duty, the first tick update yields HOLD and done.
- stop (in RAMP or HOLD) always takes priority over a same-cycle start.
- pwm_enable = 1 in RAMP, HOLD and STOPPING.

## Timing
- Reset values: duty_out = 0, freq_out = 0, pwm_enable = 0, busy = 0, at_target = 0, done = 0, state IDLE, tick counter 0.
- All outputs are registered.
- start sampled at edge N → busy = 1 and freq_out updated after edge N.
- First duty update at edge N+per+1; subsequent updates every per+1 cycles.
- The edge that writes the final duty also enters HOLD and raises done for exactly one cycle.
- Ramp from 0 to T takes ceil(T/stp) updates.
- stop without the macro:
  - Sampled at edge M.
  - After edge M: duty_out = 0, pwm_enable = 0, IDLE.
  - No done pulse.
- Reset asserted mid-ramp forces reset values immediately (asynchronous). No done pulse.

## Configuration
- PWM_RAMP_SOFTSTOP_EN defined:
  - stop in RAMP or HOLD → STOPPING with tgt = 0, keeping stp/per. The tick counter is cleared.
  - Duty ramps down per tick.
  - On duty reaching 0: IDLE, pwm_enable = 0, done pulse.
  - start and stop are ignored in STOPPING.
  - stop in HOLD at duty 0: first tick → IDLE + done.
- PWM_RAMP_SOFTSTOP_EN undefined: the STOPPING state is not built, and stop is immediate as described in Timing.

## Test plan
- Reset check: assert reset mid-ramp (duty 40) → all outputs 0 asynchronously, IDLE after release.
- Basic ramp: start with target 50, step 10, tick_period 3, freq_sel 2:
  - duty steps 10, 20, 30, 40, 50 every 4 cycles.
  - done is a single pulse with duty 50.
  - at_target = 1, freq_out = 2.
- Clamp and step boundaries:
  - target 200, step 30 → duty 30, 60, 90, 100 then HOLD.
  - step 0 → increments of 1.
- Retarget: in HOLD at 80, start with target 25, step 20 → 60, 40, 25, then done.
- Start with target equal to current duty (50 in HOLD) → one tick later done, duty stays 50.
- Stop:
  - Same-cycle start+stop in HOLD at 60 → stop wins.
  - Without PWM_RAMP_SOFTSTOP_EN: next cycle duty 0, pwm_enable 0, no done.
  - With PWM_RAMP_SOFTSTOP_EN and step 20: 40, 20, 0, then IDLE + done.
